fpdiv: RTL and testbench

//  Iterative single-precision divider, q = a / b; the inverse operation of the combinational fpmult.

---
 rtl/fpdiv.sv | 109 ++++++++++
 tb/tb_fpdiv.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fpdiv.sv
// Iterative binary32 divider: restoring radix-2, one quotient bit per clock.
// Truncated result, start/done handshake, divide-by-zero flag on zero/denormal divisor.
module fpdiv (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic        dz
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;

  state_t      r_state, w_state_next;
  logic        r_sign;
  logic [7:0]  r_ea, r_eb;
  logic [23:0] r_mb;
  logic [25:0] r_rem;
  logic [24:0] r_quo;
  logic [4:0]  r_cnt;
  logic        r_busy, r_done, r_dz;
  logic [31:0] r_q;

  logic [25:0] w_d, w_rem_sub;
  logic        w_ge;
  logic [7:0]  w_exp_base, w_exp;
  logic [22:0] w_fract;

  assign w_d        = {2'b00, r_mb};
  assign w_ge       = (r_rem >= w_d);
  assign w_rem_sub  = w_ge ? (r_rem - w_d) : r_rem;
  assign w_exp_base = r_ea - r_eb;
  // quotient in [1,2) keeps the biased exponent, [0.5,1) drops it by one
  assign w_exp      = r_quo[24] ? (w_exp_base + 8'd127) : (w_exp_base + 8'd126);
  assign w_fract    = r_quo[24] ? r_quo[23:1] : r_quo[22:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_DIV;
      S_DIV:   if (r_cnt == 5'd24) w_state_next = S_NORM;
      S_NORM:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sign <= 1'b0;
      r_ea   <= 8'h0;
      r_eb   <= 8'h0;
      r_mb   <= 24'h0;
      r_rem  <= 26'h0;
      r_quo  <= 25'h0;
      r_cnt  <= 5'h0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_q    <= 32'h0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign <= a[31] ^ b[31];
            r_ea   <= a[30:23];
            r_eb   <= b[30:23];
            r_mb   <= {1'b1, b[22:0]};
            r_rem  <= {3'b001, a[22:0]};
            r_quo  <= 25'h0;
            r_cnt  <= 5'h0;
            r_busy <= 1'b1;
          end
        end
        S_DIV: begin
          r_quo <= {r_quo[23:0], w_ge};
          r_rem <= {w_rem_sub[24:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        S_NORM: begin
          if (r_eb == 8'h0) begin
            r_q  <= {r_sign, 8'hFF, 23'h0};
            r_dz <= 1'b1;
          end else begin
            r_q  <= {r_sign, w_exp, w_fract};
            r_dz <= 1'b0;
          end
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign q    = r_q;
  assign dz   = r_dz;

endmodule

// File: tb/tb_fpdiv.sv
// Scoreboard bench for fpdiv: stimulus pushes reference results, a forked monitor
// pops and compares on every done pulse (value, dz flag and latency).
module tb_fpdiv;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_i = 32'h0;
  logic [31:0] b_i = 32'h0;
  logic        busy, done, dz;
  logic [31:0] q;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] q;
    logic        dz;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  fpdiv dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .q(q), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: real-valued mantissa ratio scaled by 2^24, then renormalised.
  function automatic logic [32:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    longint ma, mb, quo;
    int     e;
    logic [7:0]  ex;
    logic [22:0] fr;
    logic        s;
    s  = x[31] ^ y[31];
    ma = longint'({1'b1, x[22:0]});
    mb = longint'({1'b1, y[22:0]});
    quo = (ma * (64'd1 << 24)) / mb;
    if (quo >= (64'd1 << 24)) begin
      e  = int'(x[30:23]) - int'(y[30:23]) + 127;
      fr = 23'((quo / 2) % (64'd1 << 23));
    end else begin
      e  = int'(x[30:23]) - int'(y[30:23]) + 126;
      fr = 23'(quo % (64'd1 << 23));
    end
    ex = 8'(e);
    if (y[30:23] == 8'h0) return {1'b1, s, 8'hFF, 23'h0};
    return {1'b0, s, ex, fr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("q", q, e.q);
          chk("dz", {31'h0, dz}, {31'h0, e.dz});
          chk("latency", 32'(cyc - e.cyc), 32'd26);
          $display("done: q=%h dz=%b expected q=%h dz=%b", q, dz, e.q, e.dz);
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit expect_it);
    logic [32:0] r;
    exp_t e;
    start = 1'b1;
    a_i = x;
    b_i = y;
    @(negedge clk);
    start = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    if (expect_it) begin
      r = ref_div(x, y);
      e.q = r[31:0];
      e.dz = r[32];
      e.cyc = cyc;
      sb.push_back(e);
    end
    chk("busy_after_start", {31'h0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    issue(x, y, 1'b1);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_done", {31'h0, done}, 32'd0);
    chk("reset_q", q, 32'h0);
    chk("reset_dz", {31'h0, dz}, 32'd0);
    reset_n = 1'b1;

    op(32'h3F800000, 32'h3F800000);
    op(32'h3F800000, 32'h3FC00000);
    op(32'h40C00000, 32'h40000000);
    op(32'hC1000000, 32'h40000000);
    op(32'h40400000, 32'h00000000);
    op(32'h3F800000, 32'h3F800000);

    // start pulsed mid-DIV must be ignored
    @(negedge clk);
    issue(32'h40C00000, 32'h40000000, 1'b1);
    repeat (5) @(negedge clk);
    issue(32'h3F800000, 32'h3FC00000, 1'b0);
    wait_done();
    repeat (30) @(negedge clk);

    // reset in the middle of DIV aborts the operation
    @(negedge clk);
    issue(32'h41200000, 32'h40400000, 1'b0);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_q", q, 32'h0);
    chk("abort_dz", {31'h0, dz}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    op(32'h41200000, 32'h40400000);

    // random operands, roughly half issued back-to-back in the done cycle
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(7) == 0) rb[30:23] = 8'h0;
      issue(ra, rb, 1'b1);
      wait_done();
      if ($urandom_range(1) == 0) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
